// File: rtl/psum_drain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : psum_drain_ctrl_pkg
//  Purpose  : Shared configuration for the partial-sum drain block: default
//             operand width, array height, drain FIFO depth, the drain FSM
//             state encoding and a row-index width helper.
//  Revision : 1.0  initial release
// ============================================================================
package psum_drain_ctrl_pkg;

    localparam int DEF_DATASIZE      = 8;
    localparam int DEF_ARRAYHEIGHT   = 4;
    localparam int DRAIN_FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_e;

    // Row index width; a single-row array still needs a 1-bit field.
    function automatic int row_width(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_drain_ctrl_drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : psum_drain_ctrl_drain_fifo
//  Purpose  : Small synchronous FIFO with a registered read port. A pushed
//             entry appears on rdata_o / !empty_o the cycle after the push.
//             Simultaneous push and pop are both honoured.
//  Ports    : clk, rst        clock, synchronous active-high reset
//             push_i, wdata_i write request / data (caller respects full_o)
//             pop_i           read request (ignored when empty)
//             rdata_o         head entry
//             full_o, empty_o, count_o  occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module psum_drain_ctrl_drain_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage is cleared on reset so the head output reads zero when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : psum_drain_ctrl
//  Purpose  : Drains ARRAYHEIGHT results from the systolic-array result shift
//             register, tags each with its row index, buffers them in a skid
//             FIFO and presents them on a valid/ready stream. The shift-out
//             enable is gated on FIFO space so downstream stalls never drop
//             a word.
//  Config   : PSUM_RELU_EN - when defined, negative words are replaced by
//             zero on their way into the FIFO; otherwise bit-exact.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             start               begin one drain (only accepted when idle)
//             busy, done          activity flag, one-cycle completion pulse
//             sr_out_en, sr_data  shift-register handshake
//             m_valid, m_ready    output stream handshake
//             m_data, m_row, m_last  output word, its row, last-row flag
//  Revision : 1.0  initial release
// ============================================================================
module psum_drain_ctrl
    import psum_drain_ctrl_pkg::*;
#(
    parameter int DATASIZE    = DEF_DATASIZE,
    parameter int ARRAYHEIGHT = DEF_ARRAYHEIGHT,
    parameter int FIFO_DEPTH  = DRAIN_FIFO_DEPTH,
    parameter int ROW_W       = row_width(ARRAYHEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  sr_out_en,
    input  logic [2*DATASIZE-1:0] sr_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*DATASIZE-1:0] m_data,
    output logic [ROW_W-1:0]      m_row,
    output logic                  m_last
);

    localparam int                DW       = 2 * DATASIZE;
    localparam int                FW       = DW + ROW_W;
    localparam int                CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ARRAYHEIGHT - 1);

    drain_state_e     state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic [DW-1:0]    push_word;
    logic [FW-1:0]    fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             pop;

`ifdef PSUM_RELU_EN
    assign push_word = sr_data[DW-1] ? '0 : sr_data;
`else
    assign push_word = sr_data;
`endif

    psum_drain_ctrl_drain_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (sr_out_en),
        .wdata_i ({row_q, push_word}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign m_valid           = !fifo_empty;
    assign pop               = m_valid && m_ready;
    assign {m_row, m_data}   = fifo_rdata;
    assign m_last            = m_valid && (m_row == LAST_ROW);
    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        sr_out_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRAIN;
                    row_d   = '0;
                end
            end
            ST_DRAIN: begin
                // Only shift when a slot is free now; a same-cycle pop does
                // not earn credit, keeping the enable off the m_ready path.
                if (!fifo_full) begin
                    sr_out_en = 1'b1;
                    row_d     = row_q + ROW_W'(1);
                    if (row_q == LAST_ROW) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Leave as the FIFO goes empty so done lands the cycle right
                // after the final downstream handshake.
                if (fifo_empty || ((fifo_count == CNT_W'(1)) && pop)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psum_drain_ctrl
//  Purpose  : Self-checking bench for psum_drain_ctrl (DATASIZE=8,
//             ARRAYHEIGHT=4, FIFO_DEPTH=2). Shift-register rows hold
//             0001, FFFE, 0100, 7FFF. Expected words are queued when a drain
//             is started and compared as the stream hands them over.
//  Revision : 1.0  initial release
// ============================================================================
module tb_psum_drain_ctrl;

    localparam int AH = 4;
    localparam int DW = 16;
    localparam int RW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] row;
        logic          last;
    } exp_t;

    // mode: 0 = m_ready held high, 1 = stalled 10 cycles, 2 = toggling
    typedef struct {
        int mode;
        bit restart;
        int exp_en;
        int exp_words;
        int exp_done;
    } scen_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          sr_out_en;
    logic [DW-1:0] sr_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [RW-1:0] m_row;
    logic          m_last;
    logic          reload;

    logic [DW-1:0] sr_mem [AH];
    int            sr_idx;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   en_total = 0;
    int   done_total = 0;
    int   words_total = 0;
    int   last_hs_cyc = -10;
    bit   hold_prev = 0;
    logic [DW-1:0] prev_data;
    logic [RW-1:0] prev_row;
    logic          prev_last;

    always #5 clk = ~clk;

    psum_drain_ctrl #(
        .DATASIZE    (8),
        .ARRAYHEIGHT (AH),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .sr_out_en (sr_out_en),
        .sr_data   (sr_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_row     (m_row),
        .m_last    (m_last)
    );

    // Shift-register model: word at the head is valid while sr_out_en is high.
    assign sr_data = (sr_idx < AH) ? sr_mem[sr_idx] : 16'hDEAD;

    always @(posedge clk) begin
        if (rst || reload) sr_idx <= 0;
        else if (sr_out_en) sr_idx <= sr_idx + 1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w);
`ifdef PSUM_RELU_EN
        return w[DW-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < AH; i++) begin
            e.data = model_word(sr_mem[i]);
            e.row  = RW'(i);
            e.last = (i == AH - 1);
            expq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            hold_prev = 0;
        end else begin
            if (sr_out_en) en_total++;
            if (done) begin
                done_total++;
                chk("done_timing", cyc, last_hs_cyc + 1);
            end
            if (hold_prev) begin
                chk("hold_data", m_data, prev_data);
                chk("hold_row", m_row, prev_row);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_word", m_data, 0);
                    chk("unexpected_word_flag", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("m_data", m_data, e.data);
                    chk("m_row", m_row, e.row);
                    chk("m_last", m_last, e.last);
                    words_total++;
                    if (m_last) last_hs_cyc = cyc;
                end
            end
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
            prev_row  = m_row;
            prev_last = m_last;
        end
    end

    task automatic run_drain(input scen_t s);
        int en0, d0, w0, first_en, last_en, k;
        bit seen_done;
        en0 = en_total;
        d0  = done_total;
        w0  = words_total;
        first_en = -1;
        last_en  = -1;
        seen_done = 0;
        push_expected();
        reload = 1'b1;
        start  = 1'b1;
        m_ready = (s.mode == 0);
        tick();
        reload = 1'b0;
        start  = 1'b0;
        for (k = 0; k < 300 && !seen_done; k++) begin
            if (sr_out_en) begin
                if (first_en < 0) first_en = k;
                last_en = k;
            end
            if (s.mode == 1 && k == 9) begin
                chk("stall_en_cycles", en_total - en0, 2);
                chk("stall_valid", m_valid, 1);
                chk("stall_head", m_data, model_word(16'h0001));
            end
            case (s.mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k >= 10);
                default: m_ready = (k % 2 == 0);
            endcase
            start = s.restart && (k == 1);
            tick();
            if (done) seen_done = 1;
        end
        start = 1'b0;
        if (!seen_done) chk("done_timeout", 0, 1);
        m_ready = 1'b1;
        repeat (4) tick();
        if (s.mode == 0) chk("en_consecutive", last_en - first_en, AH - 1);
        chk("en_cycles", en_total - en0, s.exp_en);
        chk("words_out", words_total - w0, s.exp_words);
        chk("done_count", done_total - d0, s.exp_done);
        chk("busy_after", busy, 0);
        chk("queue_drained", expq.size(), 0);
    endtask

    initial begin
        scen_t tbl[4];
        int k, en0;
        tbl[0] = '{mode: 0, restart: 1'b0, exp_en: 4, exp_words: 4, exp_done: 1};
        tbl[1] = '{mode: 1, restart: 1'b0, exp_en: 4, exp_words: 4, exp_done: 1};
        tbl[2] = '{mode: 2, restart: 1'b0, exp_en: 4, exp_words: 4, exp_done: 1};
        tbl[3] = '{mode: 0, restart: 1'b1, exp_en: 4, exp_words: 4, exp_done: 1};

        sr_mem[0] = 16'h0001;
        sr_mem[1] = 16'hFFFE;
        sr_mem[2] = 16'h0100;
        sr_mem[3] = 16'h7FFF;

        rst = 1'b1;
        start = 1'b0;
        m_ready = 1'b0;
        reload = 1'b0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sr_out_en", sr_out_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_row", m_row, 0);
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            run_drain(tbl[i]);
        end

        // Reset in the middle of a stalled drain.
        push_expected();
        en0 = en_total;
        m_ready = 1'b0;
        reload = 1'b1;
        start = 1'b1;
        tick();
        reload = 1'b0;
        start = 1'b0;
        for (k = 0; k < 50 && (en_total - en0) < 2; k++) tick();
        chk("midrst_en_before", en_total - en0, 2);
        rst = 1'b1;
        tick();
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sr_out_en", sr_out_en, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        expq.delete();
        tick();
        run_drain(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
